// File: rtl/trigger_capture_buffer_pkg.sv
// Shared definitions for the trigger capture buffer: capture states, index sizing
// and the signed trigger-crossing test.
package trigger_capture_buffer_pkg;

    typedef enum logic [1:0] {
        WAIT_TRIGGER = 2'd0,
        CAPTURE      = 2'd1,
        FULL         = 2'd2
    } captureState_e;

    function automatic int indexBits(input int displayWidth);
        return $clog2(displayWidth);
    endfunction

    // Operands arrive sign-extended to 32 bits, so any DATA_BITS width compares correctly.
    function automatic logic triggerCrossed(
        input logic signed [31:0] prevSample,
        input logic signed [31:0] currSample,
        input logic signed [31:0] level,
        input logic               rising
    );
        if (rising) begin
            return (prevSample < level) && (currSample >= level);
        end
        return (prevSample > level) && (currSample <= level);
    endfunction

endpackage

// File: rtl/trigger_capture_buffer_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, single clock.
module sample_ram #(
    parameter int DATA_BITS  = 12,
    parameter int DEPTH_BITS = 11
) (
    input  logic                  clock,
    input  logic                  writeEnable_i,
    input  logic [DEPTH_BITS-1:0] writeAddress_i,
    input  logic [DATA_BITS-1:0]  writeData_i,
    input  logic [DEPTH_BITS-1:0] readAddress_i,
    output logic [DATA_BITS-1:0]  readData_o
);

    logic [DATA_BITS-1:0] mem_q [2**DEPTH_BITS];
    logic [DATA_BITS-1:0] readData_q;

    always_ff @(posedge clock) begin
        if (writeEnable_i) begin
            mem_q[writeAddress_i] <= writeData_i;
        end
        readData_q <= mem_q[readAddress_i];
    end

    assign readData_o = readData_q;

endmodule

// File: rtl/trigger_capture_buffer.sv
// Detects a trigger crossing in the ADC stream, captures one display-width frame into
// a double-buffered RAM and serves the frozen frame to the renderer.
module trigger_capture_buffer
    import trigger_capture_buffer_pkg::*;
#(
    parameter int DATA_BITS     = 12,
    parameter int ADDRESS_BITS  = 12,
    parameter int DISPLAY_WIDTH = 1024,
    parameter int AUTO_TIMEOUT  = 65536
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           sampleValid,
    input  logic signed [DATA_BITS-1:0]    sampleIn,
    input  logic signed [DATA_BITS-1:0]    triggerLevel,
    input  logic                           triggerRising,
    input  logic                           drawStarting,
    input  logic        [ADDRESS_BITS-1:0] address,
    output logic signed [DATA_BITS-1:0]    dataOut,
    output logic                           frameReady,
    output logic                           displayValid,
    output logic                           autoTriggered
);

    localparam int INDEX_BITS   = indexBits(DISPLAY_WIDTH);
    localparam int TIMEOUT_BITS = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam logic [INDEX_BITS-1:0]   LAST_INDEX   = INDEX_BITS'(DISPLAY_WIDTH - 1);
    localparam logic [TIMEOUT_BITS-1:0] TIMEOUT_LAST = TIMEOUT_BITS'(AUTO_TIMEOUT - 1);

    captureState_e                state_q, state_d;
    logic                         writeBank_q, writeBank_d;
    logic [INDEX_BITS-1:0]        writeIndex_q, writeIndex_d;
    logic                         hasPrev_q, hasPrev_d;
    logic signed [DATA_BITS-1:0]  prevSample_q, prevSample_d;
    logic [TIMEOUT_BITS-1:0]      timeoutCount_q, timeoutCount_d;
    logic                         pendingAuto_q, pendingAuto_d;
    logic                         frameReady_q, frameReady_d;
    logic                         displayValid_q, displayValid_d;
    logic                         autoTriggered_q, autoTriggered_d;
    logic                         readValid_q;

    logic                         realTrigger;
    logic                         autoTrigger;
    logic                         writeEnable;
    logic [INDEX_BITS:0]          writeAddress;
    logic [DATA_BITS-1:0]         ramData;
    logic                         unusedAddress;

    assign unusedAddress = ^address;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= WAIT_TRIGGER;
            writeBank_q     <= 1'b0;
            writeIndex_q    <= '0;
            hasPrev_q       <= 1'b0;
            prevSample_q    <= '0;
            timeoutCount_q  <= '0;
            pendingAuto_q   <= 1'b0;
            frameReady_q    <= 1'b0;
            displayValid_q  <= 1'b0;
            autoTriggered_q <= 1'b0;
            readValid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            writeBank_q     <= writeBank_d;
            writeIndex_q    <= writeIndex_d;
            hasPrev_q       <= hasPrev_d;
            prevSample_q    <= prevSample_d;
            timeoutCount_q  <= timeoutCount_d;
            pendingAuto_q   <= pendingAuto_d;
            frameReady_q    <= frameReady_d;
            displayValid_q  <= displayValid_d;
            autoTriggered_q <= autoTriggered_d;
            readValid_q     <= displayValid_q;
        end
    end

    always_comb begin
        state_d         = state_q;
        writeBank_d     = writeBank_q;
        writeIndex_d    = writeIndex_q;
        hasPrev_d       = hasPrev_q;
        prevSample_d    = prevSample_q;
        timeoutCount_d  = timeoutCount_q;
        pendingAuto_d   = pendingAuto_q;
        frameReady_d    = frameReady_q;
        displayValid_d  = displayValid_q;
        autoTriggered_d = autoTriggered_q;
        writeEnable     = 1'b0;
        writeAddress    = {writeBank_q, writeIndex_q};
        realTrigger     = hasPrev_q && triggerCrossed(32'(prevSample_q), 32'(sampleIn),
                                                      32'(triggerLevel), triggerRising);
        autoTrigger     = (AUTO_TIMEOUT != 0) && (timeoutCount_q == TIMEOUT_LAST);

        case (state_q)
            WAIT_TRIGGER: begin
                if (sampleValid) begin
                    prevSample_d   = sampleIn;
                    hasPrev_d      = 1'b1;
                    timeoutCount_d = timeoutCount_q + TIMEOUT_BITS'(1);
                    // A real crossing on the timeout sample takes priority over the auto flag.
                    if (realTrigger || autoTrigger) begin
                        writeEnable    = 1'b1;
                        writeAddress   = {writeBank_q, {INDEX_BITS{1'b0}}};
                        writeIndex_d   = INDEX_BITS'(1);
                        timeoutCount_d = '0;
                        pendingAuto_d  = !realTrigger;
                        state_d        = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (sampleValid) begin
                    writeEnable  = 1'b1;
                    writeIndex_d = writeIndex_q + INDEX_BITS'(1);
                    if (writeIndex_q == LAST_INDEX) begin
                        frameReady_d = 1'b1;
                        state_d      = FULL;
                    end
                end
            end
            FULL: begin
                if (drawStarting) begin
                    writeBank_d     = !writeBank_q;
                    displayValid_d  = 1'b1;
                    autoTriggered_d = pendingAuto_q;
                    frameReady_d    = 1'b0;
                    hasPrev_d       = 1'b0;
                    writeIndex_d    = '0;
                    state_d         = WAIT_TRIGGER;
                end
            end
            default: state_d = WAIT_TRIGGER;
        endcase
    end

    sample_ram #(
        .DATA_BITS (DATA_BITS),
        .DEPTH_BITS(INDEX_BITS + 1)
    ) sampleRam (
        .clock         (clock),
        .writeEnable_i (writeEnable),
        .writeAddress_i(writeAddress),
        .writeData_i   (sampleIn),
        .readAddress_i ({!writeBank_q, address[INDEX_BITS-1:0]}),
        .readData_o    (ramData)
    );

    assign dataOut       = readValid_q ? $signed(ramData) : '0;
    assign frameReady    = frameReady_q;
    assign displayValid  = displayValid_q;
    assign autoTriggered = autoTriggered_q;

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Self-checking bench for trigger_capture_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based frame model.
module tb_trigger_capture_buffer;

    localparam int DATA_BITS     = 12;
    localparam int ADDRESS_BITS  = 12;
    localparam int DISPLAY_WIDTH = 16;
    localparam int AUTO_TIMEOUT  = 8;

    logic                           clock = 1'b0;
    logic                           reset_n;
    logic                           sampleValid;
    logic signed [DATA_BITS-1:0]    sampleIn;
    logic signed [DATA_BITS-1:0]    triggerLevel;
    logic                           triggerRising;
    logic                           drawStarting;
    logic        [ADDRESS_BITS-1:0] address;
    logic signed [DATA_BITS-1:0]    dataOut;
    logic                           frameReady;
    logic                           displayValid;
    logic                           autoTriggered;

    int checks = 0;
    int errors = 0;

    // Reference model: the displayed frame, the frame being collected, and trigger history.
    int shownFrame [DISPLAY_WIDTH];
    int captureQ [$];
    bit haveShown, shownAuto, captureAuto, lastValid;
    int lastSample, waitCount, expData;

    always #5 clock = ~clock;

    trigger_capture_buffer #(
        .DATA_BITS    (DATA_BITS),
        .ADDRESS_BITS (ADDRESS_BITS),
        .DISPLAY_WIDTH(DISPLAY_WIDTH),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sampleValid  (sampleValid),
        .sampleIn     (sampleIn),
        .triggerLevel (triggerLevel),
        .triggerRising(triggerRising),
        .drawStarting (drawStarting),
        .address      (address),
        .dataOut      (dataOut),
        .frameReady   (frameReady),
        .displayValid (displayValid),
        .autoTriggered(autoTriggered)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] got,
                               input logic signed [31:0] expected);
        checks++;
        assert (got === expected) else begin
            errors++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, expected);
        end
    endtask

    // Applies the frame rules to the inputs present at one rising edge.
    task automatic modelEdge();
        int s;
        int lvl;
        bit realHit;
        bit autoHit;
        s   = sampleIn;
        lvl = triggerLevel;
        if (!reset_n) begin
            expData     = 0;
            captureQ.delete();
            haveShown   = 0;
            shownAuto   = 0;
            lastValid   = 0;
            lastSample  = 0;
            waitCount   = 0;
            return;
        end
        expData = haveShown ? shownFrame[int'(address) % DISPLAY_WIDTH] : 0;
        if (captureQ.size() == DISPLAY_WIDTH) begin
            if (drawStarting) begin
                foreach (shownFrame[k]) shownFrame[k] = captureQ[k];
                captureQ.delete();
                haveShown = 1;
                shownAuto = captureAuto;
                lastValid = 0;
            end
        end else if (captureQ.size() > 0) begin
            if (sampleValid) captureQ.push_back(s);
        end else if (sampleValid) begin
            realHit = lastValid && (triggerRising ? (lastSample < lvl && s >= lvl)
                                                  : (lastSample > lvl && s <= lvl));
            autoHit = (waitCount == AUTO_TIMEOUT - 1);
            lastSample = s;
            lastValid  = 1;
            if (realHit || autoHit) begin
                captureQ.push_back(s);
                captureAuto = !realHit;
                waitCount   = 0;
            end else begin
                waitCount++;
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge, checks all outputs after it.
    task automatic applyStimulus(input bit valid, input int sample, input bit draw, input int addr);
        sampleValid  = valid;
        sampleIn     = DATA_BITS'(sample);
        drawStarting = draw;
        address      = ADDRESS_BITS'(addr);
        @(posedge clock);
        modelEdge();
        #1;
        checkOutput("dataOut", dataOut, expData);
        checkOutput("frameReady", frameReady, (captureQ.size() == DISPLAY_WIDTH) ? 1 : 0);
        checkOutput("displayValid", displayValid, haveShown ? 1 : 0);
        checkOutput("autoTriggered", autoTriggered, shownAuto ? 1 : 0);
    endtask

    initial begin
        reset_n       = 1'b0;
        sampleValid   = 1'b0;
        sampleIn      = '0;
        triggerLevel  = '0;
        triggerRising = 1'b1;
        drawStarting  = 1'b0;
        address       = '0;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 9);
        checkOutput("rst_dataOut", dataOut, 0);
        checkOutput("rst_displayValid", displayValid, 0);
        checkOutput("rst_frameReady", frameReady, 0);
        reset_n = 1'b1;

        $display("[TB] rising ramp");
        for (int v = -5; v <= 20; v++) begin
            applyStimulus(1, v, 0, 3);
            if (v == 14) checkOutput("ramp_notReady", frameReady, 0);
            if (v == 15) checkOutput("ramp_ready", frameReady, 1);
        end
        applyStimulus(0, 0, 1, 3);
        checkOutput("ramp_swapReady", frameReady, 0);
        applyStimulus(0, 0, 0, 3);
        checkOutput("ramp_data3", dataOut, 3);
        checkOutput("ramp_displayValid", displayValid, 1);
        checkOutput("ramp_auto", autoTriggered, 0);

        $display("[TB] auto trigger");
        for (int i = 0; i < 30; i++) applyStimulus(1, -100, 0, 0);
        checkOutput("auto_ready", frameReady, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("auto_flag", autoTriggered, 1);
        checkOutput("auto_data", dataOut, -100);

        $display("[TB] falling trigger with early drawStarting");
        triggerRising = 1'b0;
        applyStimulus(1, 5, 0, 0);
        applyStimulus(1, 5, 0, 0);
        applyStimulus(1, -1, 0, 0);
        for (int k = 1; k < 7; k++) applyStimulus(1, k, 0, 0);
        applyStimulus(1, 7, 1, 0);
        checkOutput("early_noSwapData", dataOut, -100);
        applyStimulus(0, 0, 0, 0);
        checkOutput("early_oldFrame", dataOut, -100);
        checkOutput("early_auto", autoTriggered, 1);
        for (int k = 8; k < DISPLAY_WIDTH; k++) applyStimulus(1, k, 0, 0);
        checkOutput("fall_ready", frameReady, 1);
        applyStimulus(0, 0, 1, 5);
        checkOutput("fall_swapCycleRead", dataOut, -100);
        applyStimulus(0, 0, 0, 'h3F5);
        checkOutput("fall_wrapData", dataOut, 5);
        checkOutput("fall_auto", autoTriggered, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("fall_index0", dataOut, -1);

        $display("[TB] reset during capture");
        triggerRising = 1'b1;
        applyStimulus(1, -1, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, k, 0, 0);
        reset_n = 1'b0;
        applyStimulus(1, 9, 0, 0);
        checkOutput("midrst_displayValid", displayValid, 0);
        checkOutput("midrst_dataOut", dataOut, 0);
        reset_n = 1'b1;
        applyStimulus(1, -3, 0, 0);
        applyStimulus(1, 2, 0, 0);
        for (int k = 1; k < DISPLAY_WIDTH; k++) applyStimulus(1, 7, 0, 0);
        checkOutput("midrst_ready", frameReady, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("midrst_data", dataOut, 2);

        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) == 0) triggerRising = ~triggerRising;
            if ($urandom_range(0, 99) == 0) triggerLevel = DATA_BITS'(int'($urandom_range(0, 16)) - 8);
            reset_n = ($urandom_range(0, 399) != 0);
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)) - 32,
                          $urandom_range(0, 14) == 0, int'($urandom_range(0, 4095)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
